// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared CNN constants, layer geometry and serializer state type
package cnn_pkg;

    localparam int DATA_BITS   = 12;
    localparam int FILTER_SIZE = 3;

    localparam int L1_WIDTH    = 8;
    localparam int L1_HEIGHT   = 8;
    localparam int L1_CHANNELS = 3;

    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_DRAIN = 1'b1
    } fmap_state_t;

    // Counter width that stays at least one bit for degenerate sizes.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fmap_bank.sv
// rtl/fmap_bank.sv - multi-lane feature-map buffer with one registered read port
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset (read register only)
//   wr_en, wr_addr        write every lane at pixel address wr_addr
//   wr_data               one sample per lane
//   rd_en, rd_addr        read address {channel, pixel}; rd_data updates only on rd_en
//   rd_data               registered read sample, holds when rd_en is low
module fmap_bank #(
    parameter int CHANNELS  = 3,
    parameter int NPIX      = 64,
    parameter int DATA_BITS = 12,
    parameter int CH_W      = 2,
    parameter int PIX_W     = 6
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               wr_en,
    input  logic [PIX_W-1:0]                   wr_addr,
    input  logic [CHANNELS-1:0][DATA_BITS-1:0] wr_data,
    input  logic                               rd_en,
    input  logic [CH_W+PIX_W-1:0]              rd_addr,
    output logic [DATA_BITS-1:0]               rd_data
);

    logic [DATA_BITS-1:0] mem [CHANNELS][NPIX];
    logic [CH_W-1:0]      rd_ch;
    logic [PIX_W-1:0]     rd_pix;

    assign {rd_ch, rd_pix} = rd_addr;

    // Storage itself is never reset; only the output register is.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int c = 0; c < CHANNELS; c++) begin
                mem[c][wr_addr] <= wr_data[c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_ch][rd_pix];
        end
    end

endmodule

// File: rtl/fmap_serializer.sv
// rtl/fmap_serializer.sv - buffers one parallel-lane frame, then streams it channel by channel
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   valid_in, data_in_0..2      one conv result per lane for the current raster pixel
//   out_ready                   downstream accepts data_out this cycle
//   data_out, valid_out, ch_idx serialized sample, its valid flag and channel
//   frame_done                  pulse the cycle after the last sample is accepted
//   overflow                    sticky: an input arrived while draining
module fmap_serializer #(
    parameter int WIDTH     = cnn_pkg::L1_WIDTH,
    parameter int HEIGHT    = cnn_pkg::L1_HEIGHT,
    parameter int CHANNELS  = cnn_pkg::L1_CHANNELS,
    parameter int DATA_BITS = cnn_pkg::DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 valid_in,
    input  logic [DATA_BITS-1:0] data_in_0,
    input  logic [DATA_BITS-1:0] data_in_1,
    input  logic [DATA_BITS-1:0] data_in_2,
    input  logic                 out_ready,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid_out,
    output logic [1:0]           ch_idx,
    output logic                 frame_done,
    output logic                 overflow
);

    import cnn_pkg::*;

    localparam int NPIX  = WIDTH * HEIGHT;
    localparam int PIX_W = clog2_min1(NPIX);
    localparam int X_W   = clog2_min1(WIDTH);
    localparam int Y_W   = clog2_min1(HEIGHT);
    localparam int CH_W  = clog2_min1(CHANNELS);

    localparam logic [PIX_W-1:0] WR_LAST = PIX_W'(NPIX - 1);
    localparam logic [X_W-1:0]   X_LAST  = X_W'(WIDTH - 1);
    localparam logic [Y_W-1:0]   Y_LAST  = Y_W'(HEIGHT - 1);
    localparam logic [CH_W-1:0]  CH_LAST = CH_W'(CHANNELS - 1);

    fmap_state_t                        state;
    logic [PIX_W-1:0]                   wr_cnt;
    logic [X_W-1:0]                     rd_x;
    logic [Y_W-1:0]                     rd_y;
    logic [CH_W-1:0]                    rd_ch;
    // Set once the final address has been read into the output register;
    // from then on a transfer ends the frame instead of fetching.
    logic                               last_fetched;

    logic [CHANNELS-1:0][DATA_BITS-1:0] lanes;
    logic [PIX_W-1:0]                   rd_pix;
    logic                               wr_en;
    logic                               fetch;
    logic                               rd_is_last;

    assign lanes[0] = data_in_0;
    if (CHANNELS > 1) begin : g_lane1
        assign lanes[1] = data_in_1;
    end
    if (CHANNELS > 2) begin : g_lane2
        assign lanes[2] = data_in_2;
    end

    assign rd_pix     = PIX_W'(rd_y) * PIX_W'(WIDTH) + PIX_W'(rd_x);
    assign rd_is_last = (rd_x == X_LAST) && (rd_y == Y_LAST) && (rd_ch == CH_LAST);
    assign wr_en      = (state == ST_FILL) && valid_in;

    // Fetch into the output register when it is empty (first DRAIN cycle)
    // or is being emptied this cycle, which gives one sample per cycle.
    assign fetch = (state == ST_DRAIN) && !last_fetched && (!valid_out || out_ready);

    fmap_bank #(
        .CHANNELS  (CHANNELS),
        .NPIX      (NPIX),
        .DATA_BITS (DATA_BITS),
        .CH_W      (CH_W),
        .PIX_W     (PIX_W)
    ) u_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_cnt),
        .wr_data (lanes),
        .rd_en   (fetch),
        .rd_addr ({rd_ch, rd_pix}),
        .rd_data (data_out)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_FILL;
            wr_cnt       <= '0;
            rd_x         <= '0;
            rd_y         <= '0;
            rd_ch        <= '0;
            last_fetched <= 1'b0;
            valid_out    <= 1'b0;
            ch_idx       <= 2'd0;
            frame_done   <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_FILL: begin
                    if (valid_in) begin
                        if (wr_cnt == WR_LAST) begin
                            wr_cnt <= '0;
                            state  <= ST_DRAIN;
                        end else begin
                            wr_cnt <= wr_cnt + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (valid_in) begin
                        overflow <= 1'b1;
                    end
                    if (fetch) begin
                        // Counters advance past the final address back to zero,
                        // so they are already cleared when the frame ends.
                        if (rd_x == X_LAST) begin
                            rd_x <= '0;
                            if (rd_y == Y_LAST) begin
                                rd_y  <= '0;
                                rd_ch <= (rd_ch == CH_LAST) ? '0 : rd_ch + 1'b1;
                            end else begin
                                rd_y <= rd_y + 1'b1;
                            end
                        end else begin
                            rd_x <= rd_x + 1'b1;
                        end
                        last_fetched <= rd_is_last;
                        valid_out    <= 1'b1;
                        ch_idx       <= 2'(rd_ch);
                    end else if (valid_out && out_ready) begin
                        valid_out    <= 1'b0;
                        frame_done   <= 1'b1;
                        last_fetched <= 1'b0;
                        state        <= ST_FILL;
                    end
                end
                default: state <= ST_FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_fmap_serializer.sv
// tb/tb_fmap_serializer.sv - directed self-checking bench for fmap_serializer
module tb_fmap_serializer;

    localparam int NPIX  = 64;
    localparam int TOTAL = 192;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in;
    logic [11:0] data_in_0, data_in_1, data_in_2;
    logic        out_ready;
    logic [11:0] data_out;
    logic        valid_out;
    logic [1:0]  ch_idx;
    logic        frame_done;
    logic        overflow;

    int n_cmp = 0;
    int n_bad = 0;

    logic [11:0] cap_data[$];
    logic [1:0]  cap_ch[$];
    int          fd_count;
    int          fd_at;
    logic        fd_vout;
    int          stable_err;
    int          first_valid;

    fmap_serializer #(
        .WIDTH     (8),
        .HEIGHT    (8),
        .CHANNELS  (3),
        .DATA_BITS (12)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_in   (valid_in),
        .data_in_0  (data_in_0),
        .data_in_1  (data_in_1),
        .data_in_2  (data_in_2),
        .out_ready  (out_ready),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .ch_idx     (ch_idx),
        .frame_done (frame_done),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Pixel value for lane c, pixel p under a stimulus mode.
    function automatic logic [11:0] pix(input int mode, input int c, input int p);
        case (mode)
            0:       return 12'(c * 100 + p);
            1:       return 12'(1000 + c * 100 + p);
            default: return (((p + c) % 2) == 0) ? 12'h800 : 12'h7FF;
        endcase
    endfunction

    // Counts captured samples that differ from the expected channel-major order.
    function automatic int seq_errors(input int mode, input int n, output int first_bad);
        int errs;
        errs = 0;
        first_bad = -1;
        for (int i = 0; i < n; i++) begin
            if (i >= cap_data.size() || cap_data[i] !== pix(mode, i / NPIX, i % NPIX)
                || cap_ch[i] !== 2'(i / NPIX)) begin
                errs++;
                if (first_bad < 0) first_bad = i;
            end
        end
        return errs;
    endfunction

    task automatic fill_frame(input int mode, input int first_p);
        for (int p = first_p; p < NPIX; p++) begin
            @(negedge clk);
            valid_in  = 1'b1;
            data_in_0 = pix(mode, 0, p);
            data_in_1 = pix(mode, 1, p);
            data_in_2 = pix(mode, 2, p);
        end
        @(negedge clk);
        valid_in = 1'b0;
    endtask

    // Captures accepted samples. ready_mode 0: always ready, 1: 1,0,0,1 pattern.
    // ovf_at: drain cycle with a stray valid_in (-1 none). stop_after: return
    // after that many transfers (0 = full frame). chain_mode >= 0: present the
    // next frame's pixel 0 in the frame_done cycle and return.
    task automatic run_drain(input int ready_mode, input int ovf_at, input int stop_after,
                             input int chain_mode);
        logic        prev_hold;
        logic [11:0] prev_data;
        logic [1:0]  prev_ch;
        int          post;
        cap_data.delete();
        cap_ch.delete();
        fd_count    = 0;
        fd_at       = -1;
        fd_vout     = 1'b0;
        stable_err  = 0;
        first_valid = -1;
        prev_hold   = 1'b0;
        prev_data   = '0;
        prev_ch     = '0;
        post        = 0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (prev_hold && (valid_out !== 1'b1 || data_out !== prev_data || ch_idx !== prev_ch))
                stable_err++;
            if (valid_out === 1'b1 && first_valid < 0) first_valid = k;
            if (frame_done === 1'b1) begin
                fd_count++;
                if (fd_at < 0) begin
                    fd_at   = cap_data.size();
                    fd_vout = valid_out;
                end
                if (chain_mode >= 0) begin
                    valid_in  = 1'b1;
                    data_in_0 = pix(chain_mode, 0, 0);
                    data_in_1 = pix(chain_mode, 1, 0);
                    data_in_2 = pix(chain_mode, 2, 0);
                    return;
                end
            end
            if (fd_at >= 0) begin
                post++;
                if (post > 4) return;
            end
            out_ready = (ready_mode == 0) ? 1'b1 : ((k % 4 == 0) || (k % 4 == 3));
            valid_in  = (k == ovf_at);
            if (valid_in) begin
                data_in_0 = 12'hABC;
                data_in_1 = 12'hABC;
                data_in_2 = 12'hABC;
            end
            if (valid_out === 1'b1 && out_ready) begin
                cap_data.push_back(data_out);
                cap_ch.push_back(ch_idx);
                if (stop_after > 0 && cap_data.size() == stop_after) begin
                    valid_in = 1'b0;
                    return;
                end
            end
            prev_hold = (valid_out === 1'b1) && !out_ready;
            prev_data = data_out;
            prev_ch   = ch_idx;
        end
        valid_in  = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        valid_in  = 1'b0;
        out_ready = 1'b1;
        data_in_0 = '0;
        data_in_1 = '0;
        data_in_2 = '0;
        repeat (3) @(negedge clk);
        n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL reset_valid_out got=%b want=0", valid_out); end
        n_cmp++; if (data_out !== 12'h000) begin n_bad++; $display("FAIL reset_data_out got=%h want=000", data_out); end
        n_cmp++; if (ch_idx !== 2'd0) begin n_bad++; $display("FAIL reset_ch_idx got=%0d want=0", ch_idx); end
        n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_frame_done got=%b want=0", frame_done); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow got=%b want=0", overflow); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        int e, fb;
        fill_frame(0, 0);
        run_drain(0, -1, 0, -1);
        n_cmp++; if (cap_data.size() != TOTAL) begin n_bad++; $display("FAIL basic_count got=%0d want=%0d", cap_data.size(), TOTAL); end
        e = seq_errors(0, TOTAL, fb);
        n_cmp++; if (e != 0) begin n_bad++; $display("FAIL basic_sequence bad=%0d first_index=%0d want=0 bad", e, fb); end
        n_cmp++; if (first_valid != 0) begin n_bad++; $display("FAIL basic_first_latency got=%0d want=0", first_valid); end
        n_cmp++; if (fd_count != 1) begin n_bad++; $display("FAIL basic_frame_done_count got=%0d want=1", fd_count); end
        n_cmp++; if (fd_at != TOTAL) begin n_bad++; $display("FAIL basic_frame_done_pos got=%0d want=%0d", fd_at, TOTAL); end
        n_cmp++; if (fd_vout !== 1'b0) begin n_bad++; $display("FAIL basic_valid_at_done got=%b want=0", fd_vout); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL basic_overflow got=%b want=0", overflow); end
    endtask

    task automatic test_backpressure;
        int e, fb;
        fill_frame(0, 0);
        run_drain(1, -1, 0, -1);
        out_ready = 1'b1;
        n_cmp++; if (cap_data.size() != TOTAL) begin n_bad++; $display("FAIL bp_count got=%0d want=%0d", cap_data.size(), TOTAL); end
        e = seq_errors(0, TOTAL, fb);
        n_cmp++; if (e != 0) begin n_bad++; $display("FAIL bp_sequence bad=%0d first_index=%0d want=0 bad", e, fb); end
        n_cmp++; if (stable_err != 0) begin n_bad++; $display("FAIL bp_hold_stable violations=%0d want=0", stable_err); end
        n_cmp++; if (fd_count != 1) begin n_bad++; $display("FAIL bp_frame_done_count got=%0d want=1", fd_count); end
    endtask

    task automatic test_overflow;
        int e, fb;
        fill_frame(0, 0);
        run_drain(0, 10, 0, -1);
        e = seq_errors(0, TOTAL, fb);
        n_cmp++; if (cap_data.size() != TOTAL || e != 0) begin n_bad++; $display("FAIL ovf_sequence count=%0d bad=%0d want count=%0d bad=0", cap_data.size(), e, TOTAL); end
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_flag got=%b want=1", overflow); end
        repeat (5) @(negedge clk);
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky got=%b want=1", overflow); end
    endtask

    task automatic test_reset_mid_drain;
        int e, fb, fd_rst;
        fill_frame(0, 0);
        run_drain(0, -1, 50, -1);
        e = seq_errors(0, 50, fb);
        n_cmp++; if (cap_data.size() != 50 || e != 0) begin n_bad++; $display("FAIL rst_partial count=%0d bad=%0d want count=50 bad=0", cap_data.size(), e); end
        @(negedge clk);
        rst_n  = 1'b0;
        fd_rst = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL rst_valid_out cycle=%0d got=%b want=0", i, valid_out); end
            if (frame_done === 1'b1) fd_rst++;
        end
        n_cmp++; if (fd_rst != 0) begin n_bad++; $display("FAIL rst_no_frame_done got=%0d want=0", fd_rst); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL rst_overflow_clear got=%b want=0", overflow); end
        rst_n = 1'b1;
        fill_frame(1, 0);
        run_drain(0, -1, 0, -1);
        e = seq_errors(1, TOTAL, fb);
        n_cmp++; if (cap_data.size() != TOTAL || e != 0) begin n_bad++; $display("FAIL rst_refill_sequence count=%0d bad=%0d first_index=%0d want count=%0d bad=0", cap_data.size(), e, fb, TOTAL); end
        n_cmp++; if (fd_count != 1) begin n_bad++; $display("FAIL rst_refill_frame_done got=%0d want=1", fd_count); end
    endtask

    task automatic test_back_to_back;
        int e, fb;
        fill_frame(0, 0);
        run_drain(0, -1, 0, 1);
        e = seq_errors(0, TOTAL, fb);
        n_cmp++; if (cap_data.size() != TOTAL || e != 0) begin n_bad++; $display("FAIL b2b_frame1 count=%0d bad=%0d want count=%0d bad=0", cap_data.size(), e, TOTAL); end
        n_cmp++; if (fd_count != 1) begin n_bad++; $display("FAIL b2b_frame1_done got=%0d want=1", fd_count); end
        fill_frame(1, 1);
        run_drain(0, -1, 0, -1);
        e = seq_errors(1, TOTAL, fb);
        n_cmp++; if (cap_data.size() != TOTAL || e != 0) begin n_bad++; $display("FAIL b2b_frame2 count=%0d bad=%0d first_index=%0d want count=%0d bad=0", cap_data.size(), e, fb, TOTAL); end
        n_cmp++; if (fd_count != 1) begin n_bad++; $display("FAIL b2b_frame2_done got=%0d want=1", fd_count); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL b2b_overflow got=%b want=0", overflow); end
    endtask

    task automatic test_extremes;
        int e, fb;
        fill_frame(2, 0);
        run_drain(0, -1, 0, -1);
        e = seq_errors(2, TOTAL, fb);
        n_cmp++; if (cap_data.size() != TOTAL || e != 0) begin n_bad++; $display("FAIL ext_sequence count=%0d bad=%0d first_index=%0d want bad=0", cap_data.size(), e, fb); end
        n_cmp++; if (cap_data.size() < 2 || cap_data[0] !== 12'h800) begin n_bad++; $display("FAIL ext_min got=%h want=800", (cap_data.size() > 0) ? cap_data[0] : 12'hxxx); end
        n_cmp++; if (cap_data.size() < 2 || cap_data[1] !== 12'h7FF) begin n_bad++; $display("FAIL ext_max got=%h want=7ff", (cap_data.size() > 1) ? cap_data[1] : 12'hxxx); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_overflow();
        test_reset_mid_drain();
        test_back_to_back();
        test_extremes();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fmap_serializer.md
FMAP_SERIALIZER -- requirements
Module: fmap_serializer

Interface
REQ-001 Parameter WIDTH, default 8: output feature-map columns per channel.
REQ-002 Parameter HEIGHT, default 8: output feature-map rows per channel.
REQ-003 Parameter CHANNELS, default 3: parallel conv result lanes.
REQ-004 Parameter DATA_BITS, default 12: sample width, two's complement.
REQ-005 clk  in  1  clock; all logic on posedge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 valid_in  in  1  one conv result per lane this cycle.
REQ-008 data_in_0..data_in_2  in  DATA_BITS each  lane c result for the current raster pixel.
REQ-009 out_ready  in  1  downstream accepts data_out this cycle.
REQ-010 data_out  out  DATA_BITS  serialized sample.
REQ-011 valid_out  out  1  data_out is valid.
REQ-012 ch_idx  out  2  channel of the current data_out.
REQ-013 frame_done  out  1  one-cycle pulse on acceptance of the last sample of a frame.
REQ-014 overflow  out  1  sticky flag: an input was dropped.

Function
REQ-015 The block SHALL have two states: FILL (reset state) and DRAIN.
REQ-016 In FILL, each valid_in cycle SHALL write all lanes at address wr_cnt, with wr_cnt counting 0..WIDTH*HEIGHT-1 in raster order.
REQ-017 A valid_in cycle with wr_cnt = WIDTH*HEIGHT-1 SHALL clear wr_cnt and enter DRAIN on the next cycle.
REQ-018 DRAIN SHALL emit samples in this order: channel 0 raster, then channel 1 raster, then channel 2 raster.
  - Total: CHANNELS*WIDTH*HEIGHT samples.
  - Read counters: rd_x (inner), rd_y, rd_ch (outer).
REQ-019 data_out and valid_out SHALL be registered; first valid_out SHALL assert 1 cycle after DRAIN entry.
REQ-020 Transfer SHALL occur when valid_out and out_ready are both high.
  - Without a transfer, data_out, ch_idx and valid_out SHALL hold.
  - With a transfer and samples remaining, the next sample SHALL appear the following cycle (full throughput).
REQ-021 On transfer of the final sample:
  - frame_done SHALL pulse in the following cycle.
  - valid_out SHALL deassert in that same cycle.
  - State SHALL return to FILL with read counters at 0.
REQ-022 valid_in during DRAIN SHALL be dropped with no buffer write, and SHALL set overflow; overflow clears only on reset.
REQ-023 valid_in in the cycle FILL->DRAIN is taken SHALL be dropped; valid_in in the frame_done cycle SHALL be accepted as pixel 0.
REQ-024 Data SHALL pass unmodified: no rounding, no sign change.
REQ-025 ch_idx SHALL equal rd_ch of the sample currently on data_out.

Reset
REQ-026 While rst_n=0 at posedge:
  - state=FILL.
  - wr_cnt, rd_x, rd_y, rd_ch = 0.
  - data_out=0, valid_out=0, ch_idx=0, frame_done=0, overflow=0.
REQ-027 Reset mid-DRAIN SHALL abort the frame with no frame_done; buffer contents need not be cleared.

Structure
REQ-028 DATA_BITS, FILTER_SIZE and per-layer WIDTH/HEIGHT/CHANNELS constants SHALL live in shared package cnn_pkg.
REQ-029 Storage SHALL be one sub-module, fmap_bank: CHANNELS-lane write port, single registered read port addressed by {ch, y*WIDTH+x}.
REQ-030 Counter widths SHALL be $clog2-derived from parameters.

Verification
REQ-031 Lane c pixel p = c*100+p, 64 valid cycles, out_ready=1: 192 outputs 0..63, 100..163, 200..263; ch_idx steps 0/1/2; frame_done pulses once after sample 263.
REQ-032 out_ready toggles 1,0,0,1 repeating: identical sequence, no duplicates or losses; data_out stable while out_ready=0.
REQ-033 valid_in=1 during DRAIN cycle 10: overflow=1 and stays 1 until reset; output sequence unchanged.
REQ-034 rst_n=0 after 50 drained samples, then refill with a new frame: valid_out=0 during reset; no frame_done; next frame drains correctly from sample 0.
REQ-035 Back-to-back frames, with the next frame's pixel 0 presented in the frame_done cycle: both frames drain correctly; overflow=0.
REQ-036 Inputs -2048 and 2047: the same values appear on data_out.
